// File: rtl/sram_delay_line_ctrl_pkg.sv
// Shared constants for the SRAM delay-line controller: FSM state encoding and
// default word/address widths of the audio SRAM.
package sram_delay_line_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 14;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

endpackage

// File: rtl/sram_delay_line_ctrl.sv
// Circular delay line on a 1rw1r SRAM: port 0 writes each accepted sample, port 1
// reads the sample d_eff positions older; the SRAM is zero-filled after reset/clear.
module sram_delay_line_ctrl
    import sram_delay_line_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  clear_req,
    input  logic [ADDR_WIDTH-1:0] delay_len,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_in,
    output logic                  ready,
    output logic                  delayed_valid,
    output logic [DATA_WIDTH-1:0] delayed_out,
    output logic                  overrun,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] ONE       = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] clr_addr_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic                  pend_clear_q;
    logic                  ready_q;
    logic                  delayed_valid_q;
    logic [DATA_WIDTH-1:0] delayed_out_q;
    logic                  overrun_q;
    logic                  csb0_q;
    logic                  web0_q;
    logic [ADDR_WIDTH-1:0] addr0_q;
    logic [DATA_WIDTH-1:0] din0_q;
    logic                  csb1_q;
    logic [ADDR_WIDTH-1:0] addr1_q;

    // A zero delay would read the word being written; the clamp keeps the ports apart.
    logic [ADDR_WIDTH-1:0] d_eff;
    logic [ADDR_WIDTH-1:0] rd_ptr_d;
    logic                  clear_now;

    assign d_eff     = (delay_len == '0) ? ONE : delay_len;
    assign rd_ptr_d  = wr_ptr_q - d_eff;
    assign clear_now = clear_req || pend_clear_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q         <= ST_CLEAR;
            clr_addr_q      <= '0;
            wr_ptr_q        <= '0;
            pend_clear_q    <= 1'b0;
            ready_q         <= 1'b0;
            delayed_valid_q <= 1'b0;
            delayed_out_q   <= '0;
            overrun_q       <= 1'b0;
            csb0_q          <= 1'b1;
            web0_q          <= 1'b1;
            addr0_q         <= '0;
            din0_q          <= '0;
            csb1_q          <= 1'b1;
            addr1_q         <= '0;
        end else begin
            // SRAM pins default to deselected; only CLEAR and the accept edge select them.
            delayed_valid_q <= 1'b0;
            csb0_q          <= 1'b1;
            web0_q          <= 1'b1;
            csb1_q          <= 1'b1;

            case (state_q)
                ST_CLEAR: begin
                    if (clear_req) begin
                        clr_addr_q <= '0;
                        overrun_q  <= 1'b0;
                    end else begin
                        csb0_q     <= 1'b0;
                        web0_q     <= 1'b0;
                        addr0_q    <= clr_addr_q;
                        din0_q     <= '0;
                        clr_addr_q <= clr_addr_q + ONE;
                        if (clr_addr_q == LAST_ADDR) begin
                            state_q <= ST_IDLE;
                            ready_q <= 1'b1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (clear_now) begin
                        state_q      <= ST_CLEAR;
                        clr_addr_q   <= '0;
                        wr_ptr_q     <= '0;
                        pend_clear_q <= 1'b0;
                        overrun_q    <= 1'b0;
                        ready_q      <= 1'b0;
                    end else if (sample_valid) begin
                        csb0_q  <= 1'b0;
                        web0_q  <= 1'b0;
                        addr0_q <= wr_ptr_q;
                        din0_q  <= sample_in;
                        csb1_q  <= 1'b0;
                        addr1_q <= rd_ptr_d;
                        state_q <= ST_ISSUE;
                        ready_q <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    wr_ptr_q <= wr_ptr_q + ONE;
                    state_q  <= ST_WAIT;
                    if (clear_req) begin
                        pend_clear_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    delayed_out_q   <= sram_dout1;
                    delayed_valid_q <= 1'b1;
                    state_q         <= ST_IDLE;
                    ready_q         <= 1'b1;
                    if (clear_req) begin
                        pend_clear_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_CLEAR;
                    clr_addr_q <= '0;
                    ready_q    <= 1'b0;
                end
            endcase

            // Placed after the case so a dropped sample wins over a simultaneous clear.
            if (sample_valid && ((state_q != ST_IDLE) || clear_now)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign ready         = ready_q;
    assign delayed_valid = delayed_valid_q;
    assign delayed_out   = delayed_out_q;
    assign overrun       = overrun_q;
    assign sram_csb0     = csb0_q;
    assign sram_web0     = web0_q;
    assign sram_addr0    = addr0_q;
    assign sram_din0     = din0_q;
    assign sram_csb1     = csb1_q;
    assign sram_addr1    = addr1_q;

endmodule

// File: tb/tb_sram_delay_line_ctrl.sv
// Directed bench for sram_delay_line_ctrl with a behavioural 1rw1r SRAM
// (pins captured at posedge, array access at the following negedge).
module tb_sram_delay_line_ctrl;

    logic        clk;
    logic        rst;
    logic        clear_req;
    logic [13:0] delay_len;
    logic        sample_valid;
    logic [15:0] sample_in;
    logic        ready;
    logic        delayed_valid;
    logic [15:0] delayed_out;
    logic        overrun;
    logic        csb0;
    logic        web0;
    logic [13:0] addr0;
    logic [15:0] din0;
    logic        csb1;
    logic [13:0] addr1;
    logic [15:0] dout1;

    int n_cmp  = 0;
    int n_fail = 0;

    sram_delay_line_ctrl dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .clear_req     (clear_req),
        .delay_len     (delay_len),
        .sample_valid  (sample_valid),
        .sample_in     (sample_in),
        .ready         (ready),
        .delayed_valid (delayed_valid),
        .delayed_out   (delayed_out),
        .overrun       (overrun),
        .sram_csb0     (csb0),
        .sram_web0     (web0),
        .sram_addr0    (addr0),
        .sram_din0     (din0),
        .sram_csb1     (csb1),
        .sram_addr1    (addr1),
        .sram_dout1    (dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM
    logic [15:0] mem [0:16383];
    logic        l_csb0 = 1'b1;
    logic        l_web0 = 1'b1;
    logic [13:0] l_a0   = '0;
    logic [15:0] l_din0 = '0;
    logic        l_csb1 = 1'b1;
    logic [13:0] l_a1   = '0;

    initial dout1 = '0;

    always @(posedge clk) begin
        l_csb0 <= csb0;
        l_web0 <= web0;
        l_a0   <= addr0;
        l_din0 <= din0;
        l_csb1 <= csb1;
        l_a1   <= addr1;
    end

    always @(negedge clk) begin
        if (!l_csb0 && !l_web0) mem[l_a0] <= l_din0;
        if (!l_csb1) dout1 <= mem[l_a1];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One sample through ISSUE/WAIT; optionally a second sample_valid during ISSUE
    // and/or a clear_req during WAIT.
    task automatic send(input logic [15:0] s, input logic [13:0] dl,
                        input logic [13:0] ea0, input logic [13:0] ea1,
                        input logic [15:0] eout, input bit inject, input bit clr_in_wait);
        sample_valid = 1'b1;
        sample_in    = s;
        delay_len    = dl;
        tick();
        sample_valid = 1'b0;
        chk($sformatf("s%0d csb0/csb1 issue", s), {30'd0, csb0, csb1}, 32'd0);
        chk($sformatf("s%0d addr0", s), addr0, ea0);
        chk($sformatf("s%0d addr1", s), addr1, ea1);
        chk($sformatf("s%0d din0", s), din0, s);
        if (inject) begin
            sample_valid = 1'b1;
            sample_in    = 16'd99;
        end
        tick();
        sample_valid = 1'b0;
        chk($sformatf("s%0d csb idle in wait", s), {30'd0, csb0, csb1}, 32'd3);
        chk($sformatf("s%0d no early strobe", s), delayed_valid, 1'b0);
        if (clr_in_wait) clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk($sformatf("s%0d delayed_valid", s), delayed_valid, 1'b1);
        chk($sformatf("s%0d delayed_out", s), delayed_out, eout);
        tick();
        chk($sformatf("s%0d strobe one cycle", s), delayed_valid, 1'b0);
        chk($sformatf("s%0d delayed_out held", s), delayed_out, eout);
    endtask

    logic [13:0] t2_a1  [10] = '{14'd16380, 14'd16381, 14'd16382, 14'd16383, 14'd0,
                                 14'd1, 14'd2, 14'd3, 14'd4, 14'd5};
    logic [15:0] t2_out [10] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1,
                                 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};

    initial begin
        int bad;
        int n;
        rst          = 1'b1;
        clear_req    = 1'b0;
        delay_len    = '0;
        sample_valid = 1'b0;
        sample_in    = '0;
        tick();
        chk("rst ready", ready, 1'b0);
        chk("rst delayed_valid", delayed_valid, 1'b0);
        chk("rst delayed_out", delayed_out, 16'd0);
        chk("rst overrun", overrun, 1'b0);
        chk("rst csb0/web0/csb1", {29'd0, csb0, web0, csb1}, 32'd7);
        rst = 1'b0;

        // 1: zero-fill sweep after reset
        bad = 0;
        for (int i = 0; i < 16384; i++) begin
            tick();
            if (addr0 !== i[13:0] || csb0 !== 1'b0 || web0 !== 1'b0 || din0 !== 16'd0 || csb1 !== 1'b1)
                bad++;
            if (i < 16383 && ready !== 1'b0) bad++;
        end
        chk("clear sweep errors", bad, 0);
        chk("ready after clear", ready, 1'b1);

        // 2: delay 4, samples 1..10 every 4 cycles
        for (int i = 0; i < 10; i++)
            send(16'(i + 1), 14'd4, 14'(i), t2_a1[i], t2_out[i], 1'b0, 1'b0);

        // 3: delay 0 clamps to 1; delay 16383 wraps the read pointer
        send(16'd11, 14'd0, 14'd10, 14'd9, 16'd10, 1'b0, 1'b0);
        send(16'd12, 14'd0, 14'd11, 14'd10, 16'd11, 1'b0, 1'b0);
        send(16'd13, 14'd16383, 14'd12, 14'd13, 16'd0, 1'b0, 1'b0);

        // 4: sample_valid during ISSUE is dropped
        chk("overrun before drop", overrun, 1'b0);
        send(16'd14, 14'd1, 14'd13, 14'd12, 16'd13, 1'b1, 1'b0);
        chk("overrun after drop", overrun, 1'b1);
        send(16'd15, 14'd1, 14'd14, 14'd13, 16'd14, 1'b0, 1'b0);
        chk("overrun sticky", overrun, 1'b1);

        // 5: clear during WAIT still delivers, then re-clears
        send(16'd16, 14'd1, 14'd15, 14'd14, 16'd15, 1'b0, 1'b1);
        chk("clearing after pending clear", ready, 1'b0);
        n = 0;
        while (!ready && n < 20000) begin
            tick();
            n++;
        end
        chk("ready after second clear", ready, 1'b1);
        chk("overrun cleared", overrun, 1'b0);
        send(16'd21, 14'd2, 14'd0, 14'd16382, 16'd0, 1'b0, 1'b0);
        send(16'd22, 14'd2, 14'd1, 14'd16383, 16'd0, 1'b0, 1'b0);
        send(16'd23, 14'd2, 14'd2, 14'd0, 16'd21, 1'b0, 1'b0);

        // 6: reset during ISSUE
        sample_valid = 1'b1;
        sample_in    = 16'd30;
        delay_len    = 14'd2;
        tick();
        sample_valid = 1'b0;
        chk("t6 issue addr0", addr0, 14'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6 csb0/csb1 after rst", {30'd0, csb0, csb1}, 32'd3);
        chk("t6 delayed_valid after rst", delayed_valid, 1'b0);
        chk("t6 ready after rst", ready, 1'b0);
        tick();
        chk("t6 clear restart addr0", addr0, 14'd0);
        chk("t6 clear restart csb0", csb0, 1'b0);
        tick();
        chk("t6 clear next addr0", addr0, 14'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
